// File: rtl/feistel_round_ctrl.sv
// Iterative 8-bit Feistel cipher core (4-bit halves, DES S1 round function), one round per cycle.
// Latency: accept edge + ROUNDS round edges; out_valid is high ROUNDS cycles after accept.
// Backpressure: in_ready only in IDLE; the result is held stable in DONE until out_ready.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready request handshake; in_data (8b block), in_key (12b key), in_mode (0 enc, 1 dec)
//   out_valid/out_ready result handshake; out_data (8b block)
// Parameter ROUNDS: number of rounds, 2..8.
// Macro FEISTEL_DECRYPT_EN: when defined, in_mode selects decrypt (reversed subkey order);
// when undefined, in_mode is ignored and only encryption is built.

module feistel_round_ctrl #(
    parameter int ROUNDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic [11:0] in_key,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [2:0] LAST = 3'(ROUNDS - 1);

    // DES S1, one 64-bit vector per row, column 0 in the top nibble.
    localparam logic [63:0] S1_R0 = 64'hE4D12FB83A6C5907;
    localparam logic [63:0] S1_R1 = 64'h0F74E2D1A6CB9538;
    localparam logic [63:0] S1_R2 = 64'h41E8D62BFC973A50;
    localparam logic [63:0] S1_R3 = 64'hFC8249175B3EA06D;

    function automatic logic [3:0] sbox1(input logic [1:0] row, input logic [3:0] col);
        logic [63:0] v;
        logic [5:0]  base;
        case (row)
            2'd0:    v = S1_R0;
            2'd1:    v = S1_R1;
            2'd2:    v = S1_R2;
            default: v = S1_R3;
        endcase
        base = {4'(4'd15 - col), 2'b00};
        return v[base +: 4];
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_rc;
    logic [7:0]  r_blk;
    logic [11:0] r_key;
    logic        w_mode_q;
    logic [2:0]  w_idx;
    logic [5:0]  w_k;
    logic [17:0] w_rot_unused;
    logic [3:0]  w_l;
    logic [3:0]  w_r;
    logic [5:0]  w_e;
    logic [5:0]  w_y;
    logic [3:0]  w_s;
    logic [3:0]  w_p;
    logic [3:0]  w_f;
    logic        w_accept;
    logic        w_last;

`ifdef FEISTEL_DECRYPT_EN
    logic r_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= 1'b0;
        end else if (w_accept) begin
            r_mode <= in_mode;
        end
    end

    assign w_mode_q = r_mode;
    // Decrypt walks the subkey schedule backwards.
    assign w_idx    = w_mode_q ? 3'(LAST - r_rc) : r_rc;
`else
    logic w_unused_mode;

    assign w_unused_mode = in_mode;
    assign w_mode_q      = 1'b0;
    assign w_idx         = r_rc;
`endif

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_rc == LAST);

    // rotl12(key, idx) is the top half of {key,key} << idx; only its top 6 bits are the subkey.
    assign {w_k, w_rot_unused} = {r_key, r_key} << w_idx;

    assign w_l = r_blk[7:4];
    assign w_r = r_blk[3:0];
    assign w_e = {w_r[0], w_r, w_r[3]};
    assign w_y = w_e ^ w_k;
    assign w_s = sbox1({w_y[5], w_y[0]}, w_y[4:1]);
    assign w_p = {w_s[1], w_s[3], w_s[0], w_s[2]};
    assign w_f = w_l ^ w_p;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rc    <= 3'd0;
            r_blk   <= 8'd0;
            r_key   <= 12'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_blk <= in_data;
                r_key <= in_key;
                r_rc  <= 3'd0;
            end else if (r_state == S_RUN) begin
                if (w_last) begin
                    // Last round leaves the halves unswapped so decryption mirrors encryption.
                    r_blk <= {w_f, w_r};
                end else begin
                    r_blk <= {w_r, w_f};
                    r_rc  <= r_rc + 3'd1;
                end
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_blk;

endmodule

// File: tb/tb_feistel_round_ctrl.sv
// Directed bench for feistel_round_ctrl with three instances (ROUNDS = 2, 4, 8).
// Latency, hold, reset-abort and back-to-back throughput checked against hand-computed vectors.
// Backpressure exercised by holding out_ready low in DONE with a pending request.

module tb_feistel_round_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic [11:0] in_key = 12'h000;
    logic        in_mode = 1'b0;
    logic        iv   [3];
    logic        ordy [3];
    wire         ir   [3];
    wire         ov   [3];
    wire  [7:0]  od   [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    feistel_round_ctrl #(.ROUNDS(2)) u_r2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data),
        .in_key(in_key), .in_mode(in_mode), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]));
    feistel_round_ctrl #(.ROUNDS(4)) u_r4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data),
        .in_key(in_key), .in_mode(in_mode), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]));
    feistel_round_ctrl #(.ROUNDS(8)) u_r8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data),
        .in_key(in_key), .in_mode(in_mode), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge; leaves at a negedge with the instance back in IDLE.
    task automatic run_block(input int u, input int rounds, input logic [7:0] d,
                             input logic [11:0] k, input logic m, input logic [7:0] exp,
                             input string tag);
        int edges;
        chk({tag, "_rdy"}, 32'(ir[u]), 32'd1);
        in_data = d; in_key = k; in_mode = m;
        iv[u] = 1'b1; ordy[u] = 1'b1;
        @(negedge clk);
        iv[u] = 1'b0;
        // Scramble inputs after accept; the in-flight block must not see them.
        in_data = ~d; in_key = ~k; in_mode = ~m;
        edges = 1;
        while (!ov[u] && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        chk({tag, "_lat"}, 32'(edges), 32'(rounds + 1));
        chk({tag, "_dat"}, 32'(od[u]), 32'(exp));
        @(negedge clk);
        chk({tag, "_idle"}, 32'(ir[u]), 32'd1);
        chk({tag, "_ovlo"}, 32'(ov[u]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int pulses;
        int res_n;
        int last_t;
        logic lr;
        logic sel;

        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            ordy[i] = 1'b1;
        end

        // Reset state
        #12;
        chk("rst_ov", 32'(ov[1]), 32'd0);
        chk("rst_ir", 32'(ir[1]), 32'd1);
        chk("rst_od", 32'(od[1]), 32'd0);

        // First accept on the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        run_block(1, 4, 8'hBB, 12'hCB2, 1'b0, 8'h96, "enc4");
`ifdef FEISTEL_DECRYPT_EN
        run_block(1, 4, 8'h96, 12'hCB2, 1'b1, 8'hBB, "dec4");
`else
        run_block(1, 4, 8'hBB, 12'hCB2, 1'b1, 8'h96, "m1_4");
`endif
        run_block(1, 4, 8'h5A, 12'h0F3, 1'b0, 8'h3A, "enc4b");
`ifdef FEISTEL_DECRYPT_EN
        run_block(1, 4, 8'h3A, 12'h0F3, 1'b1, 8'h5A, "dec4b");
`else
        run_block(1, 4, 8'h5A, 12'h0F3, 1'b1, 8'h3A, "m1_4b");
`endif

        // ROUNDS = 2 and 8
        run_block(0, 2, 8'hBB, 12'hCB2, 1'b0, 8'hF0, "enc2");
        run_block(2, 8, 8'hBB, 12'hCB2, 1'b0, 8'hFB, "enc8");
`ifdef FEISTEL_DECRYPT_EN
        run_block(0, 2, 8'hF0, 12'hCB2, 1'b1, 8'hBB, "dec2");
        run_block(2, 8, 8'hFB, 12'hCB2, 1'b1, 8'hBB, "dec8");
`else
        run_block(0, 2, 8'hBB, 12'hCB2, 1'b1, 8'hF0, "m1_2");
        run_block(2, 8, 8'hBB, 12'hCB2, 1'b1, 8'hFB, "m1_8");
`endif

        // Hold in DONE with a second request pending
        in_data = 8'hBB; in_key = 12'hCB2; in_mode = 1'b0;
        iv[1] = 1'b1; ordy[1] = 1'b0;
        @(negedge clk);
        in_data = 8'h5A; in_key = 12'h0F3;
        n = 1;
        while (!ov[1] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hold_lat", 32'(n), 32'd5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_ov", 32'(ov[1]), 32'd1);
            chk("hold_od", 32'(od[1]), 32'h96);
            chk("hold_ir", 32'(ir[1]), 32'd0);
        end
        ordy[1] = 1'b1;
        @(negedge clk);
        chk("hold_idle", 32'(ir[1]), 32'd1);
        chk("hold_ovlo", 32'(ov[1]), 32'd0);
        @(negedge clk);
        chk("hold_acc2", 32'(ir[1]), 32'd0);
        iv[1] = 1'b0;
        n = 1;
        while (!ov[1] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hold_lat2", 32'(n), 32'd5);
        chk("hold_dat2", 32'(od[1]), 32'h3A);
        @(negedge clk);

        // Reset two cycles after accept
        in_data = 8'hBB; in_key = 12'hCB2; in_mode = 1'b0;
        iv[1] = 1'b1; ordy[1] = 1'b1;
        @(negedge clk);
        iv[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ov", 32'(ov[1]), 32'd0);
        chk("abort_ir", 32'(ir[1]), 32'd1);
        chk("abort_od", 32'(od[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov[1]) pulses++;
        end
        chk("abort_pulses", 32'(pulses), 32'd0);
        chk("abort_ir2", 32'(ir[1]), 32'd1);

        // Back-to-back with out_ready high, alternating vectors
        sel = 1'b0;
        in_data = 8'hBB; in_key = 12'hCB2; in_mode = 1'b0;
        iv[1] = 1'b1; ordy[1] = 1'b1;
        lr = ir[1];
        res_n = 0;
        last_t = 0;
        for (int t = 1; t <= 60 && res_n < 4; t++) begin
            @(negedge clk);
            if (ov[1]) begin
                chk("b2b_dat", 32'(od[1]), (res_n % 2 == 0) ? 32'h96 : 32'h3A);
                if (res_n == 0) chk("b2b_lat", 32'(t), 32'd5);
                else            chk("b2b_gap", 32'(t - last_t), 32'd6);
                last_t = t;
                res_n++;
            end
            if (lr && iv[1]) begin
                sel = ~sel;
                in_data = sel ? 8'h5A : 8'hBB;
                in_key  = sel ? 12'h0F3 : 12'hCB2;
            end
            lr = ir[1];
        end
        iv[1] = 1'b0;
        chk("b2b_cnt", 32'(res_n), 32'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
